// File: rtl/maxterm_scanner_if.sv
// Stream and control bundle between maxterm_scanner and its environment:
// start/expect request, the vector/function loop to the block under test,
// and the maxterm index valid/ready stream with scan results.
interface maxterm_scanner_if #(
    parameter int unsigned N_VARS = 4
);
    localparam int unsigned DEPTH = 2 ** N_VARS;

    logic              start;
    logic [DEPTH-1:0]  expect_mask;
    logic [N_VARS-1:0] vec_out;
    logic              f_in;
    logic              busy;
    logic              maxterm_valid;
    logic [N_VARS-1:0] maxterm_idx;
    logic              maxterm_ready;
    logic [DEPTH-1:0]  truth;
    logic [N_VARS:0]   mt_count;
    logic              done;
    logic              mismatch;

    // Environment side: issues scans, evaluates vectors, consumes indices.
    modport master (
        output start, expect_mask, f_in, maxterm_ready,
        input  vec_out, busy, maxterm_valid, maxterm_idx, truth, mt_count, done, mismatch
    );

    // Scanner side.
    modport slave (
        input  start, expect_mask, f_in, maxterm_ready,
        output vec_out, busy, maxterm_valid, maxterm_idx, truth, mt_count, done, mismatch
    );
endinterface

// File: rtl/maxterm_scanner.sv
// Truth-table reader: sweeps all 2**N_VARS input vectors of a combinational
// block, records F per row, streams the maxterm indices (rows with F=0) in
// ascending order and compares the maxterm set against an expected mask.
module maxterm_scanner #(
    parameter int unsigned N_VARS = 4,
    parameter int unsigned SETTLE = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    maxterm_scanner_if.slave  bus
);
    localparam int unsigned DEPTH = 2 ** N_VARS;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_EMIT,
        ST_DONE
    } state_t;

    // The SAMPLE cycle counts toward the hold time, so the SETTLE state lasts
    // SETTLE cycles (skipped entirely when SETTLE=0) and each vector is held
    // SETTLE+1 cycles in total.
    localparam state_t     SCAN_ENTRY  = (SETTLE == 0) ? ST_SAMPLE : ST_SETTLE;
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [N_VARS-1:0] vec_q, vec_d;
    logic [DEPTH-1:0]  truth_q, truth_d;
    logic [N_VARS:0]   mtc_q, mtc_d;
    logic [N_VARS-1:0] ptr_q, ptr_d;
    logic [DEPTH-1:0]  exp_q, exp_d;
    logic              mism_q, mism_d;

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            vec_q   <= '0;
            truth_q <= '0;
            mtc_q   <= '0;
            ptr_q   <= '0;
            exp_q   <= '0;
            mism_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vec_q   <= vec_d;
            truth_q <= truth_d;
            mtc_q   <= mtc_d;
            ptr_q   <= ptr_d;
            exp_q   <= exp_d;
            mism_q  <= mism_d;
        end
    end

    // Next-state logic: scan sweep, maxterm emission and final comparison.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        vec_d   = vec_q;
        truth_d = truth_q;
        mtc_d   = mtc_q;
        ptr_d   = ptr_q;
        exp_d   = exp_q;
        mism_d  = mism_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    exp_d   = bus.expect_mask;
                    vec_d   = '0;
                    truth_d = '0;
                    mtc_d   = '0;
                    mism_d  = 1'b0;
                    state_d = SCAN_ENTRY;
                    cnt_d   = SETTLE_LOAD;
                end
            end

            ST_SETTLE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = ST_SAMPLE;
                end
            end

            ST_SAMPLE: begin
                truth_d[vec_q] = bus.f_in;
                if (!bus.f_in) begin
                    mtc_d = mtc_q + (N_VARS + 1)'(1);
                end
                if (vec_q == '1) begin
                    state_d = ST_EMIT;
                    ptr_d   = '0;
                end else begin
                    vec_d   = vec_q + N_VARS'(1);
                    state_d = SCAN_ENTRY;
                    cnt_d   = SETTLE_LOAD;
                end
            end

            ST_EMIT: begin
                // A minterm row advances immediately; a maxterm row waits for ready.
                if (truth_q[ptr_q] || bus.maxterm_ready) begin
                    if (ptr_q == '1) begin
                        state_d = ST_DONE;
                        mism_d  = ((~truth_q) != exp_q);
                    end else begin
                        ptr_d = ptr_q + N_VARS'(1);
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.vec_out       = vec_q;
    assign bus.busy          = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign bus.maxterm_valid = (state_q == ST_EMIT) && !truth_q[ptr_q];
    assign bus.maxterm_idx   = ptr_q;
    assign bus.truth         = truth_q;
    assign bus.mt_count      = mtc_q;
    assign bus.done          = (state_q == ST_DONE);
    assign bus.mismatch      = mism_q;

endmodule
